// File: rtl/bp_cfg_flit_tx.sv
// Config-link transmitter: accepts one config packet per handshake and
// serializes it, LSB first and behind a length header, into fixed-width flits.
module bp_cfg_flit_tx #(
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int flit_width_p     = 30,
  parameter int len_width_p      = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        cfg_w_v_i,
  input  logic [cfg_core_width_p-1:0] cfg_core_i,
  input  logic [cfg_addr_width_p-1:0] cfg_addr_i,
  input  logic [cfg_data_width_p-1:0] cfg_data_i,
  input  logic                        cfg_v_i,
  output logic                        cfg_ready_o,
  output logic [flit_width_p-1:0]     link_data_o,
  output logic                        link_v_o,
  input  logic                        link_ready_i
);

  localparam int payload_w = 1 + cfg_core_width_p + cfg_addr_width_p + cfg_data_width_p;
  localparam int frame_w   = len_width_p + payload_w;
  localparam int num_flits = (frame_w + flit_width_p - 1) / flit_width_p;
  localparam int pad_w     = num_flits * flit_width_p;
  localparam int cnt_w     = (num_flits > 1) ? $clog2(num_flits) : 1;

  localparam logic [len_width_p-1:0] c_len = len_width_p'(num_flits - 1);
  localparam logic [cnt_w-1:0]       c_last_cnt = cnt_w'(num_flits - 1);

  // The length header must be able to encode the flit count minus one.
  generate
    if ((num_flits - 1) >= (1 << len_width_p)) begin : g_len_chk
      $error("bp_cfg_flit_tx: len_width_p too small for num_flits");
    end
  endgenerate

  typedef enum logic [1:0] {
    e_reset,
    e_idle,
    e_send
  } state_e;

  state_e                  r_state;
  logic [cnt_w-1:0]        r_cnt;
  logic [pad_w-1:0]        r_frame;
  logic                    r_ready;
  logic                    r_link_v;

  logic [pad_w-1:0]        w_frame_in;
  logic [flit_width_p-1:0] w_flits [num_flits];
  logic                    w_last;

  // Frame assembled from the inputs; the cast zero-pads up to a whole flit count.
  assign w_frame_in = pad_w'({cfg_data_i, cfg_addr_i, cfg_core_i, cfg_w_v_i, c_len});

  // Slice the registered frame into flits so the output is a plain mux.
  generate
    for (genvar gi = 0; gi < num_flits; gi++) begin : g_flit
      assign w_flits[gi] = r_frame[gi*flit_width_p +: flit_width_p];
    end
  endgenerate

  assign w_last      = (r_cnt == c_last_cnt);
  assign cfg_ready_o = r_ready;
  assign link_v_o    = r_link_v;
  assign link_data_o = w_flits[r_cnt];

  // Control FSM: capture a packet in idle, walk the flit counter in send.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= e_reset;
      r_cnt    <= '0;
      r_frame  <= '0;
      r_ready  <= 1'b0;
      r_link_v <= 1'b0;
    end else begin
      case (r_state)
        e_reset: begin
          r_state <= e_idle;
          r_ready <= 1'b1;
        end
        e_idle: begin
          if (cfg_v_i) begin
            r_state  <= e_send;
            r_frame  <= w_frame_in;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_link_v <= 1'b1;
          end
        end
        e_send: begin
          if (link_ready_i) begin
            if (w_last) begin
              r_state  <= e_idle;
              r_ready  <= 1'b1;
              r_link_v <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state  <= e_idle;
          r_ready  <= 1'b1;
          r_link_v <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_flit_tx.sv
// Testbench for bp_cfg_flit_tx: directed spec vectors plus randomized packets
// checked against a frame model built from the field layout.
module tb_bp_cfg_flit_tx;

  localparam int NF = 4;
  localparam int FW = 30;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b1;
  logic          cfg_w_v_i = 1'b0;
  logic [7:0]    cfg_core_i = '0;
  logic [15:0]   cfg_addr_i = '0;
  logic [63:0]   cfg_data_i = '0;
  logic          cfg_v_i = 1'b0;
  logic          cfg_ready_o;
  logic [FW-1:0] link_data_o;
  logic          link_v_o;
  logic          link_ready_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [FW-1:0] flit_q[$];
  int            flit_t[$];
  int            acc_t[$];

  bp_cfg_flit_tx dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .cfg_w_v_i    (cfg_w_v_i),
    .cfg_core_i   (cfg_core_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_v_i      (cfg_v_i),
    .cfg_ready_o  (cfg_ready_o),
    .link_data_o  (link_data_o),
    .link_v_o     (link_v_o),
    .link_ready_i (link_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: log accepted packets and consumed flits with their cycle index.
  always @(posedge clk_i) begin
    if (cfg_v_i && cfg_ready_o) acc_t.push_back(cyc);
    if (link_v_o && link_ready_i) begin
      flit_q.push_back(link_data_o);
      flit_t.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  // Reference: frame = header | w<<5 | core<<6 | addr<<14 | data<<30, flit k = bits [30k +: 30].
  function automatic logic [FW-1:0] exp_flit(input logic w, input logic [7:0] core,
                                             input logic [15:0] addr, input logic [63:0] data,
                                             input int k);
    logic [127:0] fr;
    fr = 128'(NF - 1) | (128'(w) << 5) | (128'(core) << 6) | (128'(addr) << 14) | (128'(data) << 30);
    return fr[k*FW +: FW];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Send one packet; optionally stall link_ready_i for stall_len cycles on flit stall_flit.
  task automatic do_packet(input logic w, input logic [7:0] core, input logic [15:0] addr,
                           input logic [63:0] data, input int stall_flit, input int stall_len);
    logic [FW-1:0] exp [NF];
    for (int k = 0; k < NF; k++) exp[k] = exp_flit(w, core, addr, data, k);
    vectors++;
    if (cfg_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pkt_ready_before: got %b want 1", cfg_ready_o);
    end
    cfg_w_v_i = w; cfg_core_i = core; cfg_addr_i = addr; cfg_data_i = data;
    cfg_v_i = 1'b1; link_ready_i = 1'b1;
    tick();
    cfg_v_i = 1'b0;
    for (int k = 0; k < NF; k++) begin
      // Inputs change freely while sending; the frame must not follow them.
      cfg_w_v_i = 1'($urandom); cfg_core_i = 8'($urandom);
      cfg_addr_i = 16'($urandom); cfg_data_i = {$urandom, $urandom};
      if (k == stall_flit) begin
        link_ready_i = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          vectors++;
          if (link_v_o !== 1'b1 || link_data_o !== exp[k] || cfg_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold flit%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                     k, link_v_o, link_data_o, cfg_ready_o, exp[k]);
          end
          tick();
        end
        link_ready_i = 1'b1;
      end
      vectors++;
      if (link_v_o !== 1'b1 || link_data_o !== exp[k]) begin
        miscompares++;
        $display("FAIL flit%0d: got v=%b d=%h want v=1 d=%h", k, link_v_o, link_data_o, exp[k]);
      end else begin
        $display("flit%0d ok d=%h", k, link_data_o);
      end
      tick();
    end
    vectors++;
    if (link_v_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pkt_done: got v=%b rdy=%b want v=0 rdy=1", link_v_o, cfg_ready_o);
    end
    link_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b1;
    #2 reset_n_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (cfg_ready_o !== 1'b0 || link_v_o !== 1'b0 || link_data_o !== '0) begin
        miscompares++;
        $display("FAIL reset_hold: got rdy=%b v=%b d=%h want 0 0 0", cfg_ready_o, link_v_o, link_data_o);
      end
    end
    reset_n_i = 1'b1;
    #1;
    vectors++;
    if (cfg_ready_o !== 1'b0 || link_v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b v=%b want 0 0", cfg_ready_o, link_v_o);
    end
    tick();
    vectors++;
    if (cfg_ready_o !== 1'b1 || link_v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got rdy=%b v=%b want 1 0", cfg_ready_o, link_v_o);
    end
    $display("reset sequence checked");
  endtask

  task automatic check_literal(input string name, input logic [FW-1:0] want [NF]);
    vectors++;
    if (flit_q.size() != NF) begin
      miscompares++;
      $display("FAIL %s_count: got %0d want %0d", name, flit_q.size(), NF);
    end else begin
      for (int k = 0; k < NF; k++) begin
        vectors++;
        if (flit_q[k] !== want[k]) begin
          miscompares++;
          $display("FAIL %s_flit%0d: got %h want %h", name, k, flit_q[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_single_write();
    logic [FW-1:0] want [NF];
    want[0] = 30'h048D00E3; want[1] = 30'h0AFEF00D; want[2] = 30'h3AB6FBBF; want[3] = 30'h0000000D;
    flit_q.delete();
    do_packet(1'b1, 8'h03, 16'h1234, 64'hDEADBEEF_CAFEF00D, -1, 0);
    check_literal("single_write", want);
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] want [NF];
    want[0] = 30'h048D00E3; want[1] = 30'h0AFEF00D; want[2] = 30'h3AB6FBBF; want[3] = 30'h0000000D;
    flit_q.delete();
    do_packet(1'b1, 8'h03, 16'h1234, 64'hDEADBEEF_CAFEF00D, 1, 5);
    check_literal("backpressure", want);
  endtask

  task automatic test_read_request();
    logic [FW-1:0] want [NF];
    want[0] = 30'h00000003; want[1] = '0; want[2] = '0; want[3] = '0;
    flit_q.delete();
    do_packet(1'b0, 8'h00, 16'h0000, 64'h0, -1, 0);
    check_literal("read_req", want);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ca, cb; logic [15:0] aa, ab; logic [63:0] da, db;
    ca = 8'($urandom); aa = 16'($urandom); da = {$urandom, $urandom};
    cb = 8'($urandom); ab = 16'($urandom); db = {$urandom, $urandom};
    flit_q.delete(); flit_t.delete(); acc_t.delete();
    cfg_w_v_i = 1'b1; cfg_core_i = ca; cfg_addr_i = aa; cfg_data_i = da;
    cfg_v_i = 1'b1; link_ready_i = 1'b1;
    tick();
    cfg_w_v_i = 1'b0; cfg_core_i = cb; cfg_addr_i = ab; cfg_data_i = db;
    repeat (5) tick();
    cfg_v_i = 1'b0;
    repeat (6) tick();
    link_ready_i = 1'b0;
    vectors++;
    if (acc_t.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_accepts: got %0d want 2", acc_t.size());
    end else begin
      vectors++;
      if (acc_t[1] - acc_t[0] != NF + 1) begin
        miscompares++;
        $display("FAIL b2b_spacing: got %0d want %0d", acc_t[1] - acc_t[0], NF + 1);
      end
    end
    vectors++;
    if (flit_q.size() != 2 * NF) begin
      miscompares++;
      $display("FAIL b2b_flits: got %0d want %0d", flit_q.size(), 2 * NF);
    end else begin
      for (int i = 0; i < 2 * NF; i++) begin
        logic [FW-1:0] e;
        e = (i < NF) ? exp_flit(1'b1, ca, aa, da, i) : exp_flit(1'b0, cb, ab, db, i - NF);
        vectors++;
        if (flit_q[i] !== e) begin
          miscompares++;
          $display("FAIL b2b_flit%0d: got %h want %h", i, flit_q[i], e);
        end
        if (i % NF != 0) begin
          vectors++;
          if (flit_t[i] != flit_t[i-1] + 1) begin
            miscompares++;
            $display("FAIL b2b_gap%0d: got cycle %0d want %0d", i, flit_t[i], flit_t[i-1] + 1);
          end
        end
      end
    end
    $display("back-to-back checked, %0d flits", flit_q.size());
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] c; logic [15:0] a; logic [63:0] d;
    cfg_w_v_i = 1'b1; cfg_core_i = 8'h5A; cfg_addr_i = 16'hBEEF; cfg_data_i = 64'h0123_4567_89AB_CDEF;
    cfg_v_i = 1'b1; link_ready_i = 1'b1;
    tick();
    cfg_v_i = 1'b0;
    tick();
    tick();
    vectors++;
    if (link_v_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: got v=%b want 1", link_v_o);
    end
    reset_n_i = 1'b0;
    #1;
    vectors++;
    if (link_v_o !== 1'b0 || cfg_ready_o !== 1'b0 || link_data_o !== '0) begin
      miscompares++;
      $display("FAIL midrst_async: got v=%b rdy=%b d=%h want 0 0 0", link_v_o, cfg_ready_o, link_data_o);
    end
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();
    vectors++;
    if (link_v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_no_retx: got v=%b want 0", link_v_o);
    end
    c = 8'($urandom); a = 16'($urandom); d = {$urandom, $urandom};
    flit_q.delete();
    do_packet(1'b1, c, a, d, -1, 0);
    vectors++;
    if (flit_q.size() != NF || flit_q[0][4:0] !== 5'(NF - 1)) begin
      miscompares++;
      $display("FAIL midrst_restart: got n=%0d want %0d with header %0d", flit_q.size(), NF, NF - 1);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 25; p++) begin
      int sf, sl;
      sf = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NF - 1)) : -1;
      sl = int'($urandom_range(1, 4));
      do_packet(1'($urandom), 8'($urandom), 16'($urandom), {$urandom, $urandom}, sf, sl);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_read_request();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
